sha_pad_ctrl: RTL and testbench
===============================

Name: sha_pad_ctrl

Overview:
- Upstream control stage for the 64-bit padding packet mux.
- Accepts a message as a stream of 64-bit words and emits one registered 64-bit word per output handshake: the raw word (pkt), and the mux selects pad_pkt, zero_pkt and mgln_pkt.
- Tracks the word position inside a WORDS_PER_BLK-word block. After the last message word it sequences one pad word, then zero words, then the message-length word, so that every message ends on a block boundary.
- Supplies msg_len, the message length in bits, to the mux.

Parameters:
- WORDS_PER_BLK, 8, words per block. Must be a power of two and at least 2. The length word always occupies index WORDS_PER_BLK-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data/in_last valid.
- in_data  input  64  message word.
- in_last  input  1  marks the final word of the message.
- in_ready  output  1  block accepts the input word this cycle.
- out_ready  input  1  downstream accepts the output word.
- out_valid  output  1  output register holds a word.
- pkt  output  64  message word; 0 when not a data word.
- msg_len  output  64  message length in bits.
- pad_pkt  output  1  output word is the pad word.
- zero_pkt  output  1  output word is a zero word.
- mgln_pkt  output  1  output word is the length word.
- blk_last  output  1  output word is at index WORDS_PER_BLK-1.
- msg_done  output  1  equals mgln_pkt (last word of the message).

Behaviour:
- Reset (asynchronous, immediate):
  - out_valid=0, pkt=0, msg_len=0, all select outputs=0, blk_last=0.
  - state=IDLE, widx=0.
  - Reset mid-message discards all progress; no partial padding is emitted.
- Load condition: load = !out_valid || out_ready. On a load cycle, the output register captures the next word.
- Stall: when out_valid && !out_ready, all outputs hold stable and nothing advances.
- widx:
  - 3-bit index (log2 WORDS_PER_BLK bits) of the word being loaded.
  - Increments on every load and wraps WORDS_PER_BLK-1 -> 0.
  - blk_last is registered as (widx == WORDS_PER_BLK-1) at load.
- in_ready = load && (state==IDLE || state==MSG). It is combinational from out_valid, out_ready and state.
- Latency: an input word accepted at cycle N is presented on the outputs at cycle N+1 with out_valid=1.
- out_valid transitions:
  - A load in the IDLE or MSG state with in_valid=0 sets out_valid=0 (bubble).
  - A load in PAD, ZERO or MGLN always sets out_valid=1.
- States:
  - IDLE (first word of a message): on load with in_valid, load pkt=in_data with all selects=0, set msg_len=64. If in_last, go to PAD; else go to MSG.
  - MSG: on load with in_valid, load pkt=in_data, msg_len += 64. If in_last, go to PAD.
  - PAD: on load, pad_pkt=1, pkt=0. If the next widx == WORDS_PER_BLK-1, go to MGLN; else go to ZERO.
  - ZERO: on load, zero_pkt=1, pkt=0. Same exit test as PAD: next widx == WORDS_PER_BLK-1 goes to MGLN, otherwise stay in ZERO.
  - MGLN: on load, mgln_pkt=1, pkt=0, msg_done=1. Go to IDLE; widx wraps to 0.
- Pad at the last index: if the last data word lands at index WORDS_PER_BLK-2, the pad word takes index WORDS_PER_BLK-1. The block then emits WORDS_PER_BLK-1 zero words in the next block, followed by the length word.
- msg_len arithmetic:
  - msg_len = word_count*64, computed with a 64-bit add that wraps modulo 2^64.
  - Held constant from the last data word through the length word.
  - Overwritten only when the next message's first word loads.
- Selects are one-hot or all-zero; at most one of pad_pkt, zero_pkt, mgln_pkt is ever high.
- Zero-length messages are not supported: every message carries at least one word with in_last.
- Back-to-back messages: a new message's first word may load in the cycle directly after the length-word load. There are no idle cycles when in_valid and out_ready are both high.

Test Plan:
- 1-word message 0xDEADBEEF_00000001, out_ready=1 -> 8 outputs: data@0, pad@1, zero@2..6, mgln@7 with msg_len=64. blk_last only on the mgln word.
- 6-word message -> data@0..5, pad@6, mgln@7, msg_len=384, no zero words.
- 7-word message -> data@0..6, pad@7 (blk_last=1), zero@0..6 of the second block, mgln@7, msg_len=448. 16 outputs total.
- Backpressure: out_ready toggled 1,0,0,1 during the PAD/ZERO words -> outputs stable while stalled, in_ready=0, no word skipped or duplicated.
- Reset asserted mid-ZERO of a 3-word message -> out_valid and selects clear immediately. Next 1-word message yields msg_len=64 with pad at index 1.
- Two 2-word messages back-to-back with continuous in_valid -> 16 consecutive out_valid cycles, both length words = 128. Second message's first word immediately follows the first mgln.

Source files
------------

// File: rtl/sha_pad_ctrl.sv
// Control stage for the 64-bit SHA padding packet mux: registers message words
// and sequences pad, zero and length words so each message ends on a block boundary.
module sha_pad_ctrl #(
  parameter int WORDS_PER_BLK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [63:0] pkt,
  output logic [63:0] msg_len,
  output logic        pad_pkt,
  output logic        zero_pkt,
  output logic        mgln_pkt,
  output logic        blk_last,
  output logic        msg_done
);

  localparam int IDX_W = $clog2(WORDS_PER_BLK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLK - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSG,
    S_PAD,
    S_ZERO,
    S_MGLN
  } state_e;

  state_e      state_q, state_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [IDX_W-1:0] widx_inc;
  logic        out_valid_q, out_valid_d;
  logic [63:0] pkt_q, pkt_d;
  logic [63:0] msg_len_q, msg_len_d;
  logic        pad_q, pad_d;
  logic        zero_q, zero_d;
  logic        mgln_q, mgln_d;
  logic        blk_last_q, blk_last_d;
  logic        load;
  logic        in_ready_c;

  // The output register may take a new word whenever it is empty or being drained.
  assign load     = !out_valid_q || out_ready;
  assign widx_inc = widx_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    out_valid_d = out_valid_q;
    pkt_d       = pkt_q;
    msg_len_d   = msg_len_q;
    pad_d       = pad_q;
    zero_d      = zero_q;
    mgln_d      = mgln_q;
    blk_last_d  = blk_last_q;
    in_ready_c  = 1'b0;

    if (load) begin
      case (state_q)
        S_IDLE, S_MSG: begin
          in_ready_c  = 1'b1;
          out_valid_d = 1'b0;
          pkt_d       = '0;
          pad_d       = 1'b0;
          zero_d      = 1'b0;
          mgln_d      = 1'b0;
          blk_last_d  = 1'b0;
          if (in_valid) begin
            out_valid_d = 1'b1;
            pkt_d       = in_data;
            blk_last_d  = (widx_q == LAST_IDX);
            widx_d      = widx_inc;
            // First word restarts the length; later words accumulate modulo 2^64.
            msg_len_d   = (state_q == S_IDLE) ? 64'd64 : msg_len_q + 64'd64;
            state_d     = in_last ? S_PAD : S_MSG;
          end
        end

        S_PAD, S_ZERO, S_MGLN: begin
          out_valid_d = 1'b1;
          pkt_d       = '0;
          pad_d       = (state_q == S_PAD);
          zero_d      = (state_q == S_ZERO);
          mgln_d      = (state_q == S_MGLN);
          blk_last_d  = (widx_q == LAST_IDX);
          widx_d      = widx_inc;
          if (state_q == S_MGLN) begin
            state_d = S_IDLE;
          end else begin
            state_d = (widx_inc == LAST_IDX) ? S_MGLN : S_ZERO;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      widx_q      <= '0;
      out_valid_q <= 1'b0;
      pkt_q       <= '0;
      msg_len_q   <= '0;
      pad_q       <= 1'b0;
      zero_q      <= 1'b0;
      mgln_q      <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      out_valid_q <= out_valid_d;
      pkt_q       <= pkt_d;
      msg_len_q   <= msg_len_d;
      pad_q       <= pad_d;
      zero_q      <= zero_d;
      mgln_q      <= mgln_d;
      blk_last_q  <= blk_last_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign pkt       = pkt_q;
  assign msg_len   = msg_len_q;
  assign pad_pkt   = pad_q;
  assign zero_pkt  = zero_q;
  assign mgln_pkt  = mgln_q;
  assign blk_last  = blk_last_q;
  assign msg_done  = mgln_q;

endmodule

// File: tb/tb_sha_pad_ctrl.sv
// Bench for sha_pad_ctrl: a queue model expands each accepted message into its
// padded word stream; a negedge monitor compares every handshaked output.
module tb_sha_pad_ctrl;
  localparam int WPB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, pad_pkt, zero_pkt, mgln_pkt, blk_last, msg_done;
  logic [63:0] pkt, msg_len;

  sha_pad_ctrl #(.WORDS_PER_BLK(WPB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid), .pkt(pkt),
    .msg_len(msg_len), .pad_pkt(pad_pkt), .zero_pkt(zero_pkt), .mgln_pkt(mgln_pkt),
    .blk_last(blk_last), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  // kind: 0 data, 1 pad, 2 zero, 3 length
  typedef struct {
    int          kind;
    logic [63:0] pkt;
    logic [63:0] len;
    logic        bl;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   mode = 0;      // 0: out_ready held 1, 1: random, 2: driven by hand
  bit   gaps = 0;
  int   pos = 0;
  int   wcnt = 0;
  longint cyc = 0;

  int          log_n = 0;
  int          log_kind[64];
  logic [63:0] log_len[64];
  logic [63:0] log_pkt[64];
  logic        log_bl[64];
  longint      log_cyc[64];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int kind_of(input logic p, input logic z, input logic m);
    if (m) return 3;
    if (z) return 2;
    if (p) return 1;
    return 0;
  endfunction

  // Expand an accepted word into expected outputs; the last word also appends
  // the pad word, zero fill up to index WPB-1, and the length word.
  task automatic model_accept(input logic [63:0] data, input logic last);
    exp_t e;
    logic [63:0] len;
    wcnt++;
    len    = 64'(wcnt) * 64'd64;
    e.kind = 0; e.pkt = data; e.len = len; e.bl = (pos % WPB == WPB - 1);
    exp_q.push_back(e);
    pos++;
    if (last) begin
      e.kind = 1; e.pkt = '0; e.len = len; e.bl = (pos % WPB == WPB - 1);
      exp_q.push_back(e);
      pos++;
      while (pos % WPB != WPB - 1) begin
        e.kind = 2; e.bl = 1'b0;
        exp_q.push_back(e);
        pos++;
      end
      e.kind = 3; e.bl = 1'b1;
      exp_q.push_back(e);
      pos  = 0;
      wcnt = 0;
    end
  endtask

  logic        prev_stall = 1'b0;
  logic        prev_acc = 1'b0;
  logic [63:0] prev_data, sv_pkt, sv_len;
  logic [4:0]  sv_flags;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
      prev_acc   = 1'b0;
    end else begin
      check64("onehot", 64'($countones({pad_pkt, zero_pkt, mgln_pkt}) <= 1), 64'd1);
      check64("msg_done", 64'(msg_done), 64'(mgln_pkt));
      if (prev_acc) begin
        check64("latency_valid", 64'(out_valid), 64'd1);
        check64("latency_pkt", pkt, prev_data);
      end
      if (prev_stall) begin
        check64("stall_pkt", pkt, sv_pkt);
        check64("stall_len", msg_len, sv_len);
        check64("stall_flags", 64'({out_valid, pad_pkt, zero_pkt, mgln_pkt, blk_last}), 64'(sv_flags));
      end
      if (out_valid && !out_ready) check64("stall_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got kind %0d pkt %h, expected no word", kind_of(pad_pkt, zero_pkt, mgln_pkt), pkt);
        end else begin
          e = exp_q.pop_front();
          check64("kind", 64'(kind_of(pad_pkt, zero_pkt, mgln_pkt)), 64'(e.kind));
          check64("pkt", pkt, e.pkt);
          check64("msg_len", msg_len, e.len);
          check64("blk_last", 64'(blk_last), 64'(e.bl));
        end
        if (log_n < 64) begin
          log_kind[log_n] = kind_of(pad_pkt, zero_pkt, mgln_pkt);
          log_len[log_n]  = msg_len;
          log_pkt[log_n]  = pkt;
          log_bl[log_n]   = blk_last;
          log_cyc[log_n]  = cyc;
          log_n++;
        end
      end
      if (in_valid && in_ready) model_accept(in_data, in_last);
      prev_acc   = in_valid && in_ready;
      prev_data  = in_data;
      prev_stall = out_valid && !out_ready;
      sv_pkt     = pkt;
      sv_len     = msg_len;
      sv_flags   = {out_valid, pad_pkt, zero_pkt, mgln_pkt, blk_last};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else if (mode == 0) out_ready = 1'b1;
  endtask

  task automatic send_msg(input int n, input bit rnd, input logic [63:0] base);
    bit acc;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = rnd ? {$urandom, $urandom} : base + 64'(k);
      in_last  = (k == n - 1);
      acc = 1'b0;
      for (int t = 0; t < 2000 && !acc; t++) begin
        #1;
        acc = in_ready;
        tick();
      end
      if (!acc) begin
        tests++;
        fails++;
        $display("FAIL in_ready_timeout: got in_ready 0 for 2000 cycles, required 1");
      end
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int t = 0; t < 3000 && exp_q.size() > 0; t++) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
    end
  endtask

  task automatic check_single_block(input string tag, input logic [63:0] d0);
    check64({tag, "_count"}, 64'(log_n), 64'd8);
    check64({tag, "_k0"}, 64'(log_kind[0]), 64'd0);
    check64({tag, "_pkt0"}, log_pkt[0], d0);
    check64({tag, "_k1"}, 64'(log_kind[1]), 64'd1);
    for (int i = 2; i < 7; i++) check64({tag, "_kzero"}, 64'(log_kind[i]), 64'd2);
    check64({tag, "_k7"}, 64'(log_kind[7]), 64'd3);
    check64({tag, "_len7"}, log_len[7], 64'd64);
    check64({tag, "_bl6"}, 64'(log_bl[6]), 64'd0);
    check64({tag, "_bl7"}, 64'(log_bl[7]), 64'd1);
  endtask

  initial begin
    int zeros;
    repeat (2) @(posedge clk);
    #1;
    check64("rst_valid", 64'(out_valid), 64'd0);
    check64("rst_pkt", pkt, 64'd0);
    check64("rst_len", msg_len, 64'd0);
    check64("rst_sel", 64'({pad_pkt, zero_pkt, mgln_pkt, blk_last}), 64'd0);
    rst = 1'b0;
    tick();

    // 1-word message
    log_n = 0;
    send_msg(1, 1'b0, 64'hDEADBEEF_00000001);
    drain();
    check_single_block("one_word", 64'hDEADBEEF_00000001);

    // 6-word message: pad at 6, length at 7, no zeros
    log_n = 0;
    send_msg(6, 1'b0, 64'h100);
    drain();
    check64("six_count", 64'(log_n), 64'd8);
    check64("six_k5", 64'(log_kind[5]), 64'd0);
    check64("six_k6", 64'(log_kind[6]), 64'd1);
    check64("six_k7", 64'(log_kind[7]), 64'd3);
    check64("six_len7", log_len[7], 64'd384);
    zeros = 0;
    for (int i = 0; i < 8; i++) if (log_kind[i] == 2) zeros++;
    check64("six_zeros", 64'(zeros), 64'd0);

    // 7-word message: pad at last index, a full zero block follows
    log_n = 0;
    send_msg(7, 1'b0, 64'h200);
    drain();
    check64("seven_count", 64'(log_n), 64'd16);
    check64("seven_k7", 64'(log_kind[7]), 64'd1);
    check64("seven_bl7", 64'(log_bl[7]), 64'd1);
    check64("seven_k8", 64'(log_kind[8]), 64'd2);
    check64("seven_k14", 64'(log_kind[14]), 64'd2);
    check64("seven_k15", 64'(log_kind[15]), 64'd3);
    check64("seven_len15", log_len[15], 64'd448);

    // Backpressure during pad/zero words
    mode = 2;
    out_ready = 1'b1;
    log_n = 0;
    send_msg(1, 1'b0, 64'h3333);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    check64("bp_pad_shown", 64'(pad_pkt), 64'd1);
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b0; tick();
    check64("bp_stall_zero", 64'(zero_pkt), 64'd1);
    check64("bp_stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1; tick();
    mode = 0;
    drain();
    check_single_block("bp", 64'h3333);

    // Reset during the zero words of a 3-word message
    send_msg(3, 1'b1, 64'h0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int t = 0; t < 100 && !zero_pkt; t++) tick();
    check64("rr_in_zero", 64'(zero_pkt), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check64("rr_valid", 64'(out_valid), 64'd0);
    check64("rr_sel", 64'({pad_pkt, zero_pkt, mgln_pkt, blk_last}), 64'd0);
    check64("rr_len", msg_len, 64'd0);
    exp_q.delete();
    pos  = 0;
    wcnt = 0;
    tick();
    rst = 1'b0;
    tick();
    log_n = 0;
    send_msg(1, 1'b0, 64'h4444);
    drain();
    check_single_block("after_rst", 64'h4444);

    // Two 2-word messages back to back
    log_n = 0;
    send_msg(2, 1'b0, 64'h500);
    send_msg(2, 1'b0, 64'h600);
    drain();
    check64("b2b_count", 64'(log_n), 64'd16);
    check64("b2b_span", 64'(log_cyc[15] - log_cyc[0]), 64'd15);
    check64("b2b_len7", log_len[7], 64'd128);
    check64("b2b_k8", 64'(log_kind[8]), 64'd0);
    check64("b2b_pkt8", log_pkt[8], 64'h600);
    check64("b2b_len15", log_len[15], 64'd128);

    // Randomized traffic with gaps and random backpressure
    mode = 1;
    gaps = 1;
    for (int m = 0; m < 40; m++) begin
      send_msg($urandom_range(1, 20), 1'b1, 64'h0);
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
